// File: rtl/mem_xfer_bridge_if.sv
// Accelerator read/write word channels between the decode_motion_vector wrapper (master)
// and the memory-side bridge (slave).
interface mem_xfer_bridge_if;
  logic        read_enable;
  logic        finish_read;
  logic [63:0] read_addr;
  logic [63:0] read_size;
  logic [63:0] read_ready;
  logic [31:0] read_data;
  logic        write_enable;
  logic        finish_write;
  logic [63:0] write_addr;
  logic [63:0] write_size;
  logic [31:0] write_data;
  logic [63:0] write_ready;

  modport master (
    output read_enable, finish_read, read_addr, read_size,
    input  read_ready, read_data,
    output write_enable, finish_write, write_addr, write_size, write_data,
    input  write_ready
  );

  modport slave (
    input  read_enable, finish_read, read_addr, read_size,
    output read_ready, read_data,
    input  write_enable, finish_write, write_addr, write_size, write_data,
    output write_ready
  );
endinterface

// File: rtl/mem_xfer_bridge.sv
// Memory-side responder: serves accelerator word reads/writes from a local BRAM, host preload port.
// Optional XFER_CNT_EN adds rd_count/wr_count transfer counters.
module mem_xfer_bridge #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned AW     = 8,
  parameter logic [63:0] BASE   = 64'h0,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned WR_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  mem_xfer_bridge_if.slave  xfer,
  input  logic              host_en,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [31:0]       host_wdata,
  output logic [31:0]       host_rdata,
  output logic              err_addr,
  output logic              err_size,
  output logic              err_proto,
  output logic              busy
`ifdef XFER_CNT_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count
`endif
);

  localparam logic [2:0]  RD_LAST = 3'(RD_LAT - 1);
  localparam logic [2:0]  WR_LAST = 3'(WR_LAT - 1);
  localparam logic [61:0] BASE_W  = BASE[63:2];

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_RESP} state_e;

  logic [31:0] mem [DEPTH];

  state_e      rd_state_q, rd_state_d, wr_state_q, wr_state_d;
  logic [2:0]  rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic        rd_en_q, wr_en_q;
  logic        rd_defer_q, rd_defer_d;
  logic        rd_ok_q, rd_ok_d;
  logic [AW-1:0] rd_idx_q, rd_idx_d;
  logic [31:0] rd_word_q, rd_word_d;
  logic [31:0] read_data_q, read_data_d;
  logic [63:0] read_ready_q, read_ready_d, write_ready_q, write_ready_d;
  logic [31:0] host_rdata_q;
  logic        err_addr_q, err_addr_d, err_size_q, err_size_d, err_proto_q, err_proto_d;
  logic        busy_q, busy_d;

  logic        rd_req, wr_req, rd_acc, wr_acc;
  logic [61:0] rd_woff, wr_woff;
  logic        rd_live_ok, wr_live_ok;
  logic [AW-1:0] rd_live_idx, wr_live_idx;

  // Request strobes and live address decode
  assign rd_req = xfer.read_enable  & (~rd_en_q | xfer.finish_read);
  assign wr_req = xfer.write_enable & (~wr_en_q | xfer.finish_write);
  assign rd_acc = rd_req & (rd_state_q == S_IDLE);
  assign wr_acc = wr_req & (wr_state_q == S_IDLE);

  assign rd_woff     = xfer.read_addr[63:2] - BASE_W;
  assign wr_woff     = xfer.write_addr[63:2] - BASE_W;
  assign rd_live_ok  = (xfer.read_addr >= BASE) && (xfer.read_addr[1:0] == 2'b00) &&
                       (rd_woff[61:AW] == '0);
  assign wr_live_ok  = (xfer.write_addr >= BASE) && (xfer.write_addr[1:0] == 2'b00) &&
                       (wr_woff[61:AW] == '0);
  assign rd_live_idx = rd_woff[AW-1:0];
  assign wr_live_idx = wr_woff[AW-1:0];

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_state_q    <= S_IDLE;
      wr_state_q    <= S_IDLE;
      rd_cnt_q      <= 3'd0;
      wr_cnt_q      <= 3'd0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      rd_defer_q    <= 1'b0;
      rd_ok_q       <= 1'b0;
      rd_idx_q      <= '0;
      rd_word_q     <= 32'd0;
      read_data_q   <= 32'd0;
      read_ready_q  <= 64'd0;
      write_ready_q <= 64'd0;
      err_addr_q    <= 1'b0;
      err_size_q    <= 1'b0;
      err_proto_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      rd_state_q    <= rd_state_d;
      wr_state_q    <= wr_state_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_en_q       <= xfer.read_enable;
      wr_en_q       <= xfer.write_enable;
      rd_defer_q    <= rd_defer_d;
      rd_ok_q       <= rd_ok_d;
      rd_idx_q      <= rd_idx_d;
      rd_word_q     <= rd_word_d;
      read_data_q   <= read_data_d;
      read_ready_q  <= read_ready_d;
      write_ready_q <= write_ready_d;
      err_addr_q    <= err_addr_d;
      err_size_q    <= err_size_d;
      err_proto_q   <= err_proto_d;
      busy_q        <= busy_d;
    end
  end

  // Next state: a read colliding with a write waits one cycle in PEND with the counter at 0
  always_comb begin
    rd_state_d = rd_state_q;
    rd_cnt_d   = rd_cnt_q;
    wr_state_d = wr_state_q;
    wr_cnt_d   = wr_cnt_q;
    case (rd_state_q)
      S_IDLE: if (rd_acc) begin
        if (wr_acc) begin
          rd_state_d = S_PEND;
          rd_cnt_d   = 3'd0;
        end else if (RD_LAST == 3'd0) begin
          rd_state_d = S_RESP;
        end else begin
          rd_state_d = S_PEND;
          rd_cnt_d   = 3'd1;
        end
      end
      S_PEND: if (rd_cnt_q >= RD_LAST) rd_state_d = S_RESP;
              else rd_cnt_d = (rd_cnt_q == 3'd7) ? 3'd7 : rd_cnt_q + 3'd1;
      S_RESP: rd_state_d = S_IDLE;
      default: rd_state_d = S_IDLE;
    endcase
    case (wr_state_q)
      S_IDLE: if (wr_acc) begin
        if (WR_LAST == 3'd0) begin
          wr_state_d = S_RESP;
        end else begin
          wr_state_d = S_PEND;
          wr_cnt_d   = 3'd1;
        end
      end
      S_PEND: if (wr_cnt_q >= WR_LAST) wr_state_d = S_RESP;
              else wr_cnt_d = (wr_cnt_q == 3'd7) ? 3'd7 : wr_cnt_q + 3'd1;
      S_RESP: wr_state_d = S_IDLE;
      default: wr_state_d = S_IDLE;
    endcase
  end

  // Outputs and read datapath; read word is captured on its port-A issue cycle
  always_comb begin
    rd_defer_d    = rd_defer_q;
    rd_ok_d       = rd_ok_q;
    rd_idx_d      = rd_idx_q;
    rd_word_d     = rd_word_q;
    read_data_d   = read_data_q;
    if (rd_acc) begin
      rd_defer_d = wr_acc;
      rd_ok_d    = rd_live_ok;
      rd_idx_d   = rd_live_idx;
      if (!wr_acc) rd_word_d = rd_live_ok ? mem[rd_live_idx] : 32'd0;
    end else if (rd_state_q == S_PEND && rd_defer_q) begin
      rd_defer_d = 1'b0;
      rd_word_d  = rd_ok_q ? mem[rd_idx_q] : 32'd0;
    end
    if (rd_state_d == S_RESP) read_data_d = rd_word_d;
    read_ready_d  = (rd_state_d == S_RESP) ? 64'd1 : 64'd0;
    write_ready_d = (wr_state_d == S_RESP) ? 64'd1 : 64'd0;
    err_addr_d    = err_addr_q | (rd_acc & ~rd_live_ok) | (wr_acc & ~wr_live_ok);
    err_size_d    = err_size_q | (rd_acc & (xfer.read_size != 64'd4)) |
                    (wr_acc & (xfer.write_size != 64'd4));
    err_proto_d   = err_proto_q | (rd_req & (rd_state_q != S_IDLE)) |
                    (wr_req & (wr_state_q != S_IDLE));
    busy_d        = (rd_state_d != S_IDLE) | (wr_state_d != S_IDLE);
  end

  // Port A write (accelerator) is ordered after port B so it wins a same-word collision
  always_ff @(posedge clk) begin
    if (host_en && host_we) mem[host_addr] <= host_wdata;
    if (wr_acc && wr_live_ok) mem[wr_live_idx] <= xfer.write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) host_rdata_q <= 32'd0;
    else if (host_en && !host_we) host_rdata_q <= mem[host_addr];
  end

`ifdef XFER_CNT_EN
  logic [31:0] rd_count_q, wr_count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_q <= 32'd0;
      wr_count_q <= 32'd0;
    end else begin
      if (read_ready_q[0])  rd_count_q <= rd_count_q + 32'd1;
      if (write_ready_q[0]) wr_count_q <= wr_count_q + 32'd1;
    end
  end
  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif

  assign xfer.read_ready  = read_ready_q;
  assign xfer.read_data   = read_data_q;
  assign xfer.write_ready = write_ready_q;
  assign host_rdata       = host_rdata_q;
  assign err_addr         = err_addr_q;
  assign err_size         = err_size_q;
  assign err_proto        = err_proto_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_mem_xfer_bridge.sv
// Directed bench for mem_xfer_bridge: scoreboarded read/write pulses with data and latency checks.
module tb_mem_xfer_bridge;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned AW     = 8;
  localparam logic [63:0] BASE   = 64'h0;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned WR_LAT = 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_en, host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata, host_rdata;
  logic          err_addr, err_size, err_proto, busy;
`ifdef XFER_CNT_EN
  logic [31:0]   rd_count, wr_count;
`endif

  mem_xfer_bridge_if xfer ();

  mem_xfer_bridge #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .reset(reset), .xfer(xfer),
    .host_en(host_en), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .err_addr(err_addr), .err_size(err_size), .err_proto(err_proto), .busy(busy)
`ifdef XFER_CNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  int      errors = 0;
  int      checks = 0;
  int      cyc    = 0;
  int      rd_seen = 0, wr_seen = 0;
  int      exp_rd = 0, exp_wr = 0;
  rd_exp_t rd_q[$];
  int      wr_q[$];
  rd_exp_t mon_e;
  int      mon_due;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (xfer.read_ready !== 64'd0) begin
      chk("rd_pulse_expected", 64'(rd_q.size() != 0), 64'd1);
      chk("rd_ready_value", xfer.read_ready, 64'd1);
      if (rd_q.size() != 0) begin
        mon_e = rd_q.pop_front();
        chk("rd_data", 64'(xfer.read_data), 64'(mon_e.data));
        chk("rd_latency_cycle", 64'(cyc), 64'(mon_e.due));
      end
      rd_seen++;
    end
    if (xfer.write_ready !== 64'd0) begin
      chk("wr_pulse_expected", 64'(wr_q.size() != 0), 64'd1);
      chk("wr_ready_value", xfer.write_ready, 64'd1);
      if (wr_q.size() != 0) begin
        mon_due = wr_q.pop_front();
        chk("wr_latency_cycle", 64'(cyc), 64'(mon_due));
      end
      wr_seen++;
    end
  end

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_seen < target && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (rd_seen < target) begin
      checks++; errors++;
      $error("FAIL rd_timeout: seen=%0d expected=%0d", rd_seen, target);
    end
  endtask

  task automatic wait_wr(input int target);
    int n = 0;
    while (wr_seen < target && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (wr_seen < target) begin
      checks++; errors++;
      $error("FAIL wr_timeout: seen=%0d expected=%0d", wr_seen, target);
    end
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    host_en = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_en = 1'b0; host_we = 1'b0;
  endtask

  task automatic host_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    @(negedge clk);
    host_en = 1'b1; host_we = 1'b0; host_addr = a;
    @(negedge clk);
    host_en = 1'b0;
    chk(tag, 64'(host_rdata), 64'(exp));
  endtask

  task automatic read_one(input logic [63:0] a, input logic [63:0] sz, input logic [31:0] exp);
    @(negedge clk);
    xfer.read_enable = 1'b1; xfer.read_addr = a; xfer.read_size = sz;
    rd_q.push_back('{data: exp, due: cyc + int'(RD_LAT)});
    @(negedge clk);
    xfer.read_enable = 1'b0; xfer.read_size = 64'd4;
    exp_rd++;
    wait_rd(exp_rd);
  endtask

  initial begin
    reset = 1'b1;
    host_en = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = 32'd0;
    xfer.read_enable = 1'b0; xfer.finish_read = 1'b0; xfer.read_addr = 64'd0; xfer.read_size = 64'd4;
    xfer.write_enable = 1'b0; xfer.finish_write = 1'b0; xfer.write_addr = 64'd0;
    xfer.write_size = 64'd4; xfer.write_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_read_ready", xfer.read_ready, 64'd0);
    chk("rst_write_ready", xfer.write_ready, 64'd0);
    chk("rst_read_data", 64'(xfer.read_data), 64'd0);
    chk("rst_host_rdata", 64'(host_rdata), 64'd0);
    chk("rst_errs", 64'({err_addr, err_size, err_proto}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) host_write(AW'(i), 32'h10 + 32'(i));
    host_write(AW'(20), 32'h5);
    host_read("host_rb_w3", AW'(3), 32'h13);

    // Burst read of 8 words stepping by finish_read
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) xfer.read_enable = 1'b1;
      else        xfer.finish_read = 1'b1;
      xfer.read_addr = BASE + 64'(4 * i);
      rd_q.push_back('{data: 32'h10 + 32'(i), due: cyc + int'(RD_LAT)});
      @(negedge clk);
      xfer.finish_read = 1'b0;
      exp_rd++;
      wait_rd(exp_rd);
    end
    @(negedge clk);
    xfer.read_enable = 1'b0;
    chk("burst_no_errs", 64'({err_addr, err_size, err_proto}), 64'd0);

    // Write burst of 4 words at BASE+0x40
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) xfer.write_enable = 1'b1;
      else        xfer.finish_write = 1'b1;
      xfer.write_addr = BASE + 64'h40 + 64'(4 * i);
      xfer.write_data = 32'hA0 + 32'(i);
      wr_q.push_back(cyc + int'(WR_LAT));
      @(negedge clk);
      xfer.finish_write = 1'b0;
      exp_wr++;
      wait_wr(exp_wr);
    end
    @(negedge clk);
    xfer.write_enable = 1'b0;
    for (int i = 0; i < 4; i++) host_read("host_wr_burst", AW'(16 + i), 32'hA0 + 32'(i));

    // Out-of-range and misaligned reads
    chk("err_addr_clear", 64'(err_addr), 64'd0);
    read_one(BASE + 64'(4 * DEPTH), 64'd4, 32'h0);
    chk("err_addr_range", 64'(err_addr), 64'd1);
    read_one(BASE + 64'd2, 64'd4, 32'h0);
    chk("read_data_misaligned", 64'(xfer.read_data), 64'd0);

    // Wrong size still transfers a word
    chk("err_size_clear", 64'(err_size), 64'd0);
    read_one(BASE + 64'd4, 64'd8, 32'h11);
    chk("err_size_set", 64'(err_size), 64'd1);

    // Same-cycle read and write to word 20: write wins, read sees new value one cycle later
    @(negedge clk);
    xfer.read_enable = 1'b1; xfer.read_addr = BASE + 64'd80;
    xfer.write_enable = 1'b1; xfer.write_addr = BASE + 64'd80; xfer.write_data = 32'h9;
    rd_q.push_back('{data: 32'h9, due: cyc + int'(RD_LAT) + 1});
    wr_q.push_back(cyc + int'(WR_LAT));
    @(negedge clk);
    xfer.read_enable = 1'b0; xfer.write_enable = 1'b0;
    chk("busy_pending", 64'(busy), 64'd1);
    exp_rd++; exp_wr++;
    wait_rd(exp_rd);
    wait_wr(exp_wr);

    // Second finish_read while pending is ignored
    chk("err_proto_clear", 64'(err_proto), 64'd0);
    @(negedge clk);
    xfer.read_enable = 1'b1; xfer.read_addr = BASE + 64'd8;
    rd_q.push_back('{data: 32'h12, due: cyc + int'(RD_LAT)});
    @(negedge clk);
    xfer.finish_read = 1'b1; xfer.read_addr = BASE + 64'd12;
    @(negedge clk);
    xfer.finish_read = 1'b0;
    exp_rd++;
    wait_rd(exp_rd);
    @(negedge clk);
    xfer.read_enable = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("proto_one_pulse", 64'(rd_seen), 64'(exp_rd));
    chk("err_proto_set", 64'(err_proto), 64'd1);

    // Reset during read PEND drops the response and clears status
    @(negedge clk);
    xfer.read_enable = 1'b1; xfer.read_addr = BASE;
    @(negedge clk);
    reset = 1'b1; xfer.read_enable = 1'b0;
    #1;
    chk("rst_mid_ready", xfer.read_ready, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("rst_mid_no_pulse", 64'(rd_seen), 64'(exp_rd));
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_errs", 64'({err_addr, err_size, err_proto}), 64'd0);
    host_read("bram_kept_w0", AW'(0), 32'h10);
    host_read("bram_kept_w19", AW'(19), 32'hA3);
    host_read("bram_kept_w20", AW'(20), 32'h9);

    chk("rd_queue_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
